huffman_stream_decoder: RTL

Parametrised streaming successor to the single-codeword Huffman decoder. It accepts a packed, MSB-first Huffman bitstream in fixed-width words, splits it into variable-length codewords, and emits one decoded symbol per cycle over a valid/ready handshake. It sits between the bitstream DMA path and the decompressed-symbol sink. Software loads the codebook through a handshaked table port before each stream.

---
 rtl/huffman_pkg.sv | 40 ++++
 rtl/huffman_match_unit.sv | 48 ++++
 rtl/huffman_stream_decoder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared types and width helpers for the Huffman encoder/decoder family.
package huffman_pkg;

  localparam int unsigned HUF_SYM_W   = 8;
  localparam int unsigned HUF_MAX_LEN = 16;
  localparam int unsigned HUF_IN_W    = 32;

  // Bits needed to hold a code length in 0..max_len.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Bits needed to hold a bit-buffer occupancy in 0..buf_w.
  function automatic int unsigned cnt_width(input int unsigned buf_w);
    return $clog2(buf_w + 1);
  endfunction

  // Bits needed to hold a valid-bit count in 0..in_w.
  function automatic int unsigned nbits_width(input int unsigned in_w);
    return $clog2(in_w + 1);
  endfunction

  localparam int unsigned HUF_LEN_W = len_width(HUF_MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } state_t;

  // Codebook entry shared by the single-codeword encoder and decoder.
  typedef struct packed {
    logic [HUF_MAX_LEN-1:0] code;
    logic [HUF_LEN_W-1:0]   len;
    logic                   valid;
  } tbl_entry_t;

endpackage

// File: rtl/huffman_match_unit.sv
// Parallel codeword compare over the whole codebook; lowest matching index wins.
module huffman_match_unit #(
  parameter int unsigned SYM_W   = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5,
  parameter int unsigned CNT_W   = 6
) (
  input  logic [MAX_LEN-1:0]            head,
  input  logic [CNT_W-1:0]              avail,
  input  logic [(2**SYM_W)*MAX_LEN-1:0] ent_code,
  input  logic [(2**SYM_W)*LEN_W-1:0]   ent_len,
  input  logic [(2**SYM_W)-1:0]         ent_valid,
  output logic                          hit_c,
  output logic [SYM_W-1:0]              index_c,
  output logic [LEN_W-1:0]              len_c
);

  localparam int unsigned NENT = 2 ** SYM_W;

  logic [MAX_LEN-1:0] code_i;
  logic [LEN_W-1:0]   len_i;
  logic [MAX_LEN-1:0] mask_i;
  logic [MAX_LEN-1:0] aligned_i;

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit_c     = 1'b0;
    index_c   = '0;
    len_c     = '0;
    code_i    = '0;
    len_i     = '0;
    mask_i    = '0;
    aligned_i = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      code_i    = ent_code[i*MAX_LEN +: MAX_LEN];
      len_i     = ent_len[i*LEN_W +: LEN_W];
      mask_i    = ~({MAX_LEN{1'b1}} >> len_i);
      aligned_i = code_i << (LEN_W'(MAX_LEN) - len_i);
      if (ent_valid[i] && (len_i != '0) && (len_i <= LEN_W'(MAX_LEN)) &&
          (CNT_W'(len_i) <= avail) && (((head ^ aligned_i) & mask_i) == '0)) begin
        hit_c   = 1'b1;
        index_c = SYM_W'(i);
        len_c   = len_i;
      end
    end
  end

endmodule

// File: rtl/huffman_stream_decoder.sv
// Streaming MSB-first Huffman decoder: word input, one symbol per cycle output.
module huffman_stream_decoder
  import huffman_pkg::*;
#(
  parameter int unsigned SYM_W   = HUF_SYM_W,
  parameter int unsigned MAX_LEN = HUF_MAX_LEN,
  parameter int unsigned IN_W    = HUF_IN_W
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             clear,
  input  logic                             tbl_clear,
  input  logic                             tbl_valid,
  output logic                             tbl_ready,
  input  logic [SYM_W-1:0]                 tbl_sym,
  input  logic [MAX_LEN-1:0]               tbl_code,
  input  logic [len_width(MAX_LEN)-1:0]    tbl_len,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_W-1:0]                  in_data,
  input  logic                             in_last,
  input  logic [nbits_width(IN_W)-1:0]     in_nbits,
  output logic                             sym_valid,
  input  logic                             sym_ready,
  output logic [SYM_W-1:0]                 sym_data,
  output logic                             sym_last,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [31:0]                      sym_count
);

  localparam int unsigned BUF_W = IN_W + MAX_LEN;
  localparam int unsigned LEN_W = len_width(MAX_LEN);
  localparam int unsigned CNT_W = cnt_width(BUF_W);
  localparam int unsigned NB_W  = nbits_width(IN_W);
  localparam int unsigned NENT  = 2 ** SYM_W;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_seen_q, last_seen_d;
  logic [NENT-1:0]    valid_q, valid_d;
  logic               sym_valid_d;
  logic [SYM_W-1:0]   sym_data_d;
  logic               sym_last_d;
  logic [31:0]        sym_count_d;
  logic               tbl_we_c;

  logic [MAX_LEN-1:0] code_mem [NENT];
  logic [LEN_W-1:0]   len_mem  [NENT];

  logic [NENT*MAX_LEN-1:0] ent_code;
  logic [NENT*LEN_W-1:0]   ent_len;

  logic               hit;
  logic [SYM_W-1:0]   match_idx;
  logic [LEN_W-1:0]   match_len;

  logic               out_free;
  logic               fire_cond;
  logic               fire;
  logic               decode_err;
  logic [CNT_W-1:0]   consumed;
  logic [CNT_W-1:0]   rem;
  logic               in_accept;
  logic [NB_W-1:0]    nbits_eff;
  logic [CNT_W-1:0]   add;
  logic [IN_W-1:0]    word_mask;
  logic [BUF_W-1:0]   shifted;
  logic [BUF_W-1:0]   appended;

  // Codebook code/len storage; only the valid bits are reset.
  always_ff @(posedge clock) begin
    if (tbl_we_c) begin
      code_mem[tbl_sym] <= tbl_code;
      len_mem[tbl_sym]  <= tbl_len;
    end
  end

  // Flatten the codebook for the match unit.
  always_comb begin
    ent_code = '0;
    ent_len  = '0;
    for (int i = 0; i < NENT; i++) begin
      ent_code[i*MAX_LEN +: MAX_LEN] = code_mem[i];
      ent_len[i*LEN_W +: LEN_W]      = len_mem[i];
    end
  end

  huffman_match_unit #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) u_match (
    .head      (buf_q[BUF_W-1 -: MAX_LEN]),
    .avail     (cnt_q),
    .ent_code  (ent_code),
    .ent_len   (ent_len),
    .ent_valid (valid_q),
    .hit_c     (hit),
    .index_c   (match_idx),
    .len_c     (match_len)
  );

  // Decode/accept datapath: shift out the matched code, then append below what remains.
  always_comb begin
    out_free   = !sym_valid || sym_ready;
    fire_cond  = out_free && (((state_q == ST_RUN) && (cnt_q >= CNT_W'(MAX_LEN))) ||
                              ((state_q == ST_FLUSH) && (cnt_q != '0)));
    fire       = fire_cond && hit;
    decode_err = fire_cond && !hit;
    consumed   = fire ? CNT_W'(match_len) : '0;
    rem        = cnt_q - consumed;
    in_ready   = (state_q == ST_RUN) && !last_seen_q && (rem <= CNT_W'(BUF_W - IN_W));
    in_accept  = in_ready && in_valid;
    nbits_eff  = ((in_nbits == '0) || (in_nbits > NB_W'(IN_W))) ? NB_W'(IN_W) : in_nbits;
    word_mask  = in_last ? ~({IN_W{1'b1}} >> nbits_eff) : {IN_W{1'b1}};
    add        = !in_accept ? '0 : (in_last ? CNT_W'(nbits_eff) : CNT_W'(IN_W));
    shifted    = buf_q << consumed;
    appended   = in_accept ? ({in_data & word_mask, {MAX_LEN{1'b0}}} >> rem) : '0;
  end

  // Next-state and register-next logic; clear overrides everything else.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    last_seen_d = last_seen_q;
    valid_d     = valid_q;
    sym_valid_d = sym_valid;
    sym_data_d  = sym_data;
    sym_last_d  = sym_last;
    sym_count_d = sym_count;
    tbl_we_c    = 1'b0;

    if (sym_valid && sym_ready) begin
      sym_valid_d = 1'b0;
      sym_count_d = (sym_count == '1) ? sym_count : sym_count + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          buf_d       = '0;
          cnt_d       = '0;
          last_seen_d = 1'b0;
          sym_count_d = '0;
        end else if (tbl_clear) begin
          valid_d = '0;
        end else if (tbl_valid && tbl_ready) begin
          tbl_we_c         = 1'b1;
          valid_d[tbl_sym] = (tbl_len != '0);
        end
      end
      ST_RUN, ST_FLUSH: begin
        if (decode_err) begin
          state_d     = ST_ERR;
          buf_d       = '0;
          cnt_d       = '0;
          last_seen_d = 1'b0;
        end else begin
          buf_d = shifted | appended;
          cnt_d = rem + add;
          if (fire) begin
            sym_valid_d = 1'b1;
            sym_data_d  = match_idx;
            sym_last_d  = (state_q == ST_FLUSH) && (rem == '0);
          end
          if (in_accept && in_last) begin
            last_seen_d = 1'b1;
            state_d     = ST_FLUSH;
          end
          if ((state_q == ST_FLUSH) && (cnt_q == '0) && out_free) begin
            state_d = ST_DONE;
          end
        end
      end
      default: ;
    endcase

    if (clear) begin
      state_d     = ST_IDLE;
      buf_d       = '0;
      cnt_d       = '0;
      last_seen_d = 1'b0;
      valid_d     = valid_q;
      tbl_we_c    = 1'b0;
      sym_valid_d = 1'b0;
      sym_data_d  = '0;
      sym_last_d  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, table valid bits and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      valid_q     <= '0;
      sym_valid   <= 1'b0;
      sym_data    <= '0;
      sym_last    <= 1'b0;
      sym_count   <= '0;
      tbl_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      valid_q     <= valid_d;
      sym_valid   <= sym_valid_d;
      sym_data    <= sym_data_d;
      sym_last    <= sym_last_d;
      sym_count   <= sym_count_d;
      tbl_ready   <= (state_d == ST_IDLE);
      busy        <= (state_d == ST_RUN) || (state_d == ST_FLUSH);
      done        <= (state_d == ST_DONE);
      err         <= (state_d == ST_ERR);
    end
  end

endmodule
